// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared parser types: FSM states, field type, offset valid-bit position
package parser_pkg;

    localparam int PKG_FIELD_WIDTH = 8;
    localparam int OFFSET_VLD_BIT  = 7;

    typedef logic [PKG_FIELD_WIDTH-1:0] field_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/insert_field.sv
// rtl/insert_field.sv - captures a header, applies (offset,data) writes, presents the result
// Optional bit-masked writes with INSERT_FIELD_MASK_EN.
module insert_field
    import parser_pkg::*;
#(
    parameter int CANDI_NUM    = 128,
    parameter int OFFSET_WIDTH = OFFSET_VLD_BIT,
    parameter int FIELD_WIDTH  = PKG_FIELD_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_hdr_valid,
    output logic                             o_hdr_ready,
    input  logic [CANDI_NUM*FIELD_WIDTH-1:0] i_hdr_data,
    input  logic                             i_cmd_valid,
    output logic                             o_cmd_ready,
    input  logic [OFFSET_WIDTH:0]            i_cmd_offset,
    input  logic [FIELD_WIDTH-1:0]           i_cmd_data,
    input  logic                             i_cmd_last,
`ifdef INSERT_FIELD_MASK_EN
    input  logic [FIELD_WIDTH-1:0]           i_cmd_mask,
`endif
    output logic                             o_hdr_valid,
    input  logic                             i_hdr_ready,
    output logic [CANDI_NUM*FIELD_WIDTH-1:0] o_hdr_data,
    output logic [CNT_WIDTH-1:0]             o_wr_cnt,
    output logic [CNT_WIDTH-1:0]             o_drop_cnt
);

    localparam int HDR_W = CANDI_NUM * FIELD_WIDTH;

    state_t                 state_q, state_d;
    logic [HDR_W-1:0]       buf_q, buf_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic                   cmd_en;
    logic [OFFSET_WIDTH-1:0] cmd_idx;
    logic                   cmd_in_range;
    logic [FIELD_WIDTH-1:0] cmd_mask;

    assign cmd_en       = i_cmd_offset[OFFSET_WIDTH];
    assign cmd_idx      = i_cmd_offset[OFFSET_WIDTH-1:0];
    assign cmd_in_range = 32'(cmd_idx) < 32'(CANDI_NUM);

`ifdef INSERT_FIELD_MASK_EN
    assign cmd_mask = i_cmd_mask;
`else
    assign cmd_mask = '1;
`endif

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        valid_d    = valid_q;
        wr_cnt_d   = wr_cnt_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_hdr_valid) begin
                    buf_d   = i_hdr_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_cmd_valid) begin
                    // An offset with the valid bit clear is only a marker (e.g. carrying last).
                    if (cmd_en && cmd_in_range) begin
                        for (int e = 0; e < CANDI_NUM; e++) begin
                            if (32'(cmd_idx) == 32'(e)) begin
                                buf_d[e*FIELD_WIDTH +: FIELD_WIDTH] =
                                    (buf_q[e*FIELD_WIDTH +: FIELD_WIDTH] & ~cmd_mask) |
                                    (i_cmd_data & cmd_mask);
                            end
                        end
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
                        end
                    end else if (cmd_en) begin
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    if (i_cmd_last) begin
                        state_d = ST_OUT;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (i_hdr_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            valid_q    <= 1'b0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_hdr_ready = (state_q == ST_IDLE);
    assign o_cmd_ready = (state_q == ST_WRITE);
    assign o_hdr_valid = valid_q;
    assign o_hdr_data  = buf_q;
    assign o_wr_cnt    = wr_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;

endmodule
